// File: rtl/psum_drain.sv
// Read-side sequencer for the psum SRAM: drains num_inp rows at consecutive
// addresses, applies optional per-lane ReLU, and streams rows over valid/ready.
module psum_drain #(
  parameter int col       = 8,
  parameter int psum_bw   = 16,
  parameter int num_inp   = 64,
  parameter int addr_bw   = 11,
  parameter int base_addr = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic [addr_bw-1:0]       mem_a,
  input  logic [col*psum_bw-1:0]   mem_dout,
  output logic [col*psum_bw-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int ROW_W = col * psum_bw;
  localparam int CNT_W = $clog2(num_inp + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row,
                                                input logic en);
    logic signed [psum_bw-1:0] lane;
    relu_row = row;
    if (en) begin
      for (int k = 0; k < col; k++) begin
        lane = row[k*psum_bw +: psum_bw];
        if (lane < 0) relu_row[k*psum_bw +: psum_bw] = '0;
      end
    end
  endfunction

  logic [1:0]       state, state_next;
  logic [1:0]       occ, occ_next;
  logic [CNT_W-1:0] issued;
  logic             relu_q;
  logic             issue;
  logic             pop;
  logic [2:0]       fill;
  logic             rd_vld_p1;
  logic [ROW_W-1:0] push_row_p1;
  logic [ROW_W-1:0] buf0_p2, buf1_p2;

  // Stage 0: read issue, gated by buffer credits
  always_comb begin
    pop   = out_valid && out_ready;
    fill  = 3'(occ) + 3'(rd_vld_p1) - 3'(pop);
    issue = (state == S_RUN) && (fill < 3'd2) && (issued < CNT_W'(num_inp));
  end

  assign mem_cen = ~issue;
  assign mem_wen = 1'b1;

  always_comb begin
    occ_next   = 2'(3'(occ) + 3'(rd_vld_p1) - 3'(pop));
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (issue && (issued == CNT_W'(num_inp - 1))) state_next = S_FLUSH;
      S_FLUSH: if (occ_next == 2'd0 && !issue) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      occ       <= 2'd0;
      rd_vld_p1 <= 1'b0;
      issued    <= '0;
      relu_q    <= 1'b0;
      mem_a     <= addr_bw'(base_addr);
    end else begin
      state     <= state_next;
      occ       <= occ_next;
      rd_vld_p1 <= issue;
      if (state == S_IDLE && start) begin
        issued <= '0;
        relu_q <= relu_en;
        mem_a  <= addr_bw'(base_addr);
      end else if (issue) begin
        issued <= issued + 1'b1;
        mem_a  <= mem_a + 1'b1;
      end
    end
  end

  // Stage 1: SRAM data returns; ReLU applied on the way into the buffer
  assign push_row_p1 = relu_row(mem_dout, relu_q);

  // Stage 2: two-entry output buffer, buf0_p2 is the head
  always_ff @(posedge clk) begin
    if (pop && occ == 2'd2) begin
      buf0_p2 <= buf1_p2;
      if (rd_vld_p1) buf1_p2 <= push_row_p1;
    end else if (pop) begin
      if (rd_vld_p1) buf0_p2 <= push_row_p1;
    end else if (rd_vld_p1) begin
      if (occ == 2'd0) buf0_p2 <= push_row_p1;
      else             buf1_p2 <= push_row_p1;
    end
  end

  assign out_valid = (occ != 2'd0);
  assign out_data  = out_valid ? buf0_p2 : '0;
  assign busy      = (state == S_RUN) || (state == S_FLUSH);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: SRAM model, random backpressure, and a
// row-level reference model built from the per-lane data table.
module tb_psum_drain;
  localparam int COL = 8, PBW = 16, NI = 64, ABW = 11, BASE = 0;
  localparam int RW = COL * PBW;

  logic clk = 1'b0;
  logic reset, start, relu_en, out_ready;
  logic mem_cen, mem_wen, out_valid, busy, done;
  logic [ABW-1:0] mem_a;
  logic [RW-1:0]  mem_dout = '0;
  logic [RW-1:0]  out_data;

  psum_drain #(.col(COL), .psum_bw(PBW), .num_inp(NI), .addr_bw(ABW), .base_addr(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_dout(mem_dout),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  logic [RW-1:0] mem [0:(1<<ABW)-1];
  always @(posedge clk) if (!mem_cen) mem_dout <= mem[mem_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int refv [NI][COL];
  int n_tests = 0, n_fail = 0;
  int t0, rdy_mode;
  int n_iss, n_pop, first_vld, done_cnt, done_cyc, last_pop;
  int addr_err, credit_err, stab_err;
  logic hold_pend;
  logic [RW-1:0] hold_data;
  logic [RW-1:0] got [$];

  // Observation of the DUT interfaces, once per cycle on the falling edge
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (!mem_cen) begin
        if (mem_a !== ABW'(BASE + n_iss)) addr_err++;
        n_iss++;
      end
      if (out_valid && first_vld < 0) first_vld = cyc - t0;
      if (hold_pend && (!out_valid || out_data !== hold_data)) stab_err++;
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        n_pop++;
        last_pop = cyc - t0;
      end
      if (n_iss - n_pop > 2) credit_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
    end
  end

  function automatic logic [RW-1:0] model_row(input int r, input bit relu);
    logic [RW-1:0] row;
    int v;
    for (int k = 0; k < COL; k++) begin
      v = refv[r][k];
      if (relu && v < 0) v = 0;
      row[k*PBW +: PBW] = PBW'(v);
    end
    return row;
  endfunction

  task automatic load_mem(input bit spec_data);
    logic [RW-1:0] row;
    for (int a = 0; a < (1<<ABW); a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    for (int r = 0; r < NI; r++) begin
      for (int k = 0; k < COL; k++)
        refv[r][k] = spec_data ? (r*8 + k - 256) : (int'($urandom_range(0, 65535)) - 32768);
      for (int k = 0; k < COL; k++) row[k*PBW +: PBW] = PBW'(refv[r][k]);
      mem[BASE + r] = row;
    end
  endtask

  task automatic clr_mon();
    n_iss = 0; n_pop = 0; first_vld = -1; done_cnt = 0; done_cyc = -1; last_pop = -1;
    addr_err = 0; credit_err = 0; stab_err = 0; hold_pend = 1'b0;
    got.delete();
  endtask

  task automatic drive_ready();
    int rel;
    rel = cyc - t0;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rel >= 30 && rel < 40) out_ready = 1'b0;
    else out_ready = ($urandom_range(0, 99) < 30);
  endtask

  task automatic start_drain(input bit relu);
    @(posedge clk); #1;
    clr_mon();
    t0 = cyc;
    start = 1'b1; relu_en = relu;
    drive_ready();
    @(posedge clk); #1;
    start = 1'b0; relu_en = $urandom_range(0, 1);
    drive_ready();
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      drive_ready();
      if (done_cnt > 0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; relu_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (mem_cen !== 1'b1) begin n_fail++; $display("FAIL reset_cen cyc%0d got %b exp 1", i, mem_cen); end
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid cyc%0d got %b exp 0", i, out_valid); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc%0d got %b exp 0", i, busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done cyc%0d got %b exp 0", i, done); end
    end
    n_tests++; if (mem_a !== ABW'(BASE)) begin n_fail++; $display("FAIL reset_addr got %h exp %h", mem_a, ABW'(BASE)); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", out_data); end
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
  endtask

  task automatic test_stream();
    bit ok; int bad;
    load_mem(1'b1); rdy_mode = 0;
    start_drain(1'b0);
    wait_done(300, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stream_timeout got no done exp done"); end
    n_tests++; if (first_vld !== 3) begin n_fail++; $display("FAIL stream_first_valid got %0d exp 3", first_vld); end
    n_tests++; if (last_pop !== NI + 2) begin n_fail++; $display("FAIL stream_last_xfer got %0d exp %0d", last_pop, NI + 2); end
    n_tests++; if (done_cyc !== NI + 3) begin n_fail++; $display("FAIL stream_done_cycle got %0d exp %0d", done_cyc, NI + 3); end
    n_tests++; if (busy !== 1'b0 || mem_cen !== 1'b1) begin n_fail++; $display("FAIL stream_idle got busy=%b cen=%b exp 0/1", busy, mem_cen); end
    repeat (4) @(posedge clk);
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL stream_done_count got %0d exp 1", done_cnt); end
    n_tests++; if (got.size() !== NI) begin n_fail++; $display("FAIL stream_rows got %0d exp %0d", got.size(), NI); end
    n_tests++; if (addr_err !== 0) begin n_fail++; $display("FAIL stream_addr got %0d bad exp 0", addr_err); end
    bad = 0;
    for (int r = 0; r < NI && r < got.size(); r++)
      if (got[r] !== model_row(r, 1'b0)) begin
        if (bad == 0) $display("FAIL stream_data row%0d got %h exp %h", r, got[r], model_row(r, 1'b0));
        bad++;
      end
    n_tests++; if (bad != 0) n_fail++;
  endtask

  task automatic test_relu();
    bit ok; int bad, neg; logic [RW-1:0] row40;
    load_mem(1'b1); rdy_mode = 0;
    start_drain(1'b1);
    wait_done(300, ok);
    repeat (2) @(posedge clk);
    n_tests++; if (!ok || got.size() !== NI) begin n_fail++; $display("FAIL relu_rows got %0d exp %0d", got.size(), NI); end
    for (int k = 0; k < COL; k++) row40[k*PBW +: PBW] = PBW'(64 + k);
    if (got.size() > 40) begin
      n_tests++; if (got[0] !== '0) begin n_fail++; $display("FAIL relu_row0 got %h exp 0", got[0]); end
      n_tests++; if (got[40] !== row40) begin n_fail++; $display("FAIL relu_row40 got %h exp %h", got[40], row40); end
    end
    bad = 0; neg = 0;
    for (int r = 0; r < got.size(); r++) begin
      for (int k = 0; k < COL; k++) if (got[r][k*PBW + PBW - 1]) neg++;
      if (r < NI && got[r] !== model_row(r, 1'b1)) begin
        if (bad == 0) $display("FAIL relu_data row%0d got %h exp %h", r, got[r], model_row(r, 1'b1));
        bad++;
      end
    end
    n_tests++; if (neg != 0) begin n_fail++; $display("FAIL relu_negative got %0d lanes exp 0", neg); end
    n_tests++; if (bad != 0) n_fail++;
  endtask

  task automatic test_backpressure();
    bit ok, relu; int bad;
    for (int pass = 0; pass < 2; pass++) begin
      load_mem(1'b0); rdy_mode = 1; relu = $urandom_range(0, 1);
      start_drain(relu);
      wait_done(3000, ok);
      repeat (3) @(posedge clk);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_timeout pass%0d got no done exp done", pass); end
      n_tests++; if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable pass%0d got %0d exp 0", pass, stab_err); end
      n_tests++; if (credit_err !== 0) begin n_fail++; $display("FAIL bp_credit pass%0d got %0d exp 0", pass, credit_err); end
      n_tests++; if (addr_err !== 0) begin n_fail++; $display("FAIL bp_addr pass%0d got %0d exp 0", pass, addr_err); end
      n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_count pass%0d got %0d exp 1", pass, done_cnt); end
      n_tests++; if (got.size() !== NI) begin n_fail++; $display("FAIL bp_rows pass%0d got %0d exp %0d", pass, got.size(), NI); end
      bad = 0;
      for (int r = 0; r < NI && r < got.size(); r++)
        if (got[r] !== model_row(r, relu)) begin
          if (bad == 0) $display("FAIL bp_data row%0d got %h exp %h", r, got[r], model_row(r, relu));
          bad++;
        end
      n_tests++; if (bad != 0) n_fail++;
    end
    rdy_mode = 0;
  endtask

  task automatic test_abort();
    bit ok; int bad, rel;
    load_mem(1'b1); rdy_mode = 0;
    start_drain(1'b0);
    do begin
      @(posedge clk); #1;
      rel = cyc - t0;
      start = (rel == 20);
      reset = (rel != 30);
    end while (rel < 31);
    repeat (80) @(posedge clk);
    #1;
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done got %0d exp 0", done_cnt); end
    n_tests++; if (busy !== 1'b0 || mem_cen !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle got busy=%b cen=%b vld=%b exp 0/1/0", busy, mem_cen, out_valid);
    end
    n_tests++; if (addr_err !== 0) begin n_fail++; $display("FAIL abort_restart_ignored got %0d bad addr exp 0", addr_err); end
    bad = 0;
    for (int r = 0; r < got.size() && r < NI; r++) if (got[r] !== model_row(r, 1'b0)) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort_prefix got %0d bad rows exp 0", bad); end
    start_drain(1'b0);
    wait_done(300, ok);
    repeat (3) @(posedge clk);
    n_tests++; if (!ok || done_cnt !== 1) begin n_fail++; $display("FAIL abort_redrain_done got %0d exp 1", done_cnt); end
    n_tests++; if (got.size() !== NI || addr_err !== 0) begin
      n_fail++; $display("FAIL abort_redrain_rows got %0d rows/%0d bad addr exp %0d/0", got.size(), addr_err, NI);
    end
    bad = 0;
    for (int r = 0; r < NI && r < got.size(); r++) if (got[r] !== model_row(r, 1'b0)) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL abort_redrain_data got %0d bad rows exp 0", bad); end
  endtask

  initial begin
    clr_mon();
    t0 = 0; rdy_mode = 0;
    test_reset();
    test_stream();
    test_relu();
    test_backpressure();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
